// File: rtl/fx3_pkg.sv
// Shared types and constants for the FX3 slave-FIFO write arbiter.
package fx3_pkg;

    localparam int FX3_DW = 32;

    localparam logic [1:0] FX3_ADDR_SOCK0 = 2'b00;
    localparam logic [1:0] FX3_ADDR_SOCK1 = 2'b01;
    localparam logic [1:0] FX3_ADDR_RD    = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_SETUP,
        WAIT_FLAGA,
        WAIT_FLAGB,
        WRITE,
        WR_DELAY,
        RELEASE
    } fx3_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    // Offsets are scanned from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int j = 0; j < NREQ; j++) begin
                if (req[j] && ((int'(ptr) + k == j) || (int'(ptr) + k == j + NREQ)))
                    idx = IW'(j);
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int j = 0; j < NREQ; j++)
            gnt[j] = (|req) && (idx == IW'(j));
    end

endmodule

// File: rtl/fx3_wr_arbiter.sv
// Round-robin sharing of the FX3 slave-FIFO write path between NREQ stream sources.
// Optional per-requester/wait statistics are enabled with FX3_WR_ARB_STATS_EN.
module fx3_wr_arbiter
    import fx3_pkg::*;
#(
    parameter int              NREQ        = 2,
    parameter int              BURST_LEN   = 1024,
    parameter int              ADDR_SETTLE = 3,
    parameter logic [2*NREQ-1:0] ADDR_MAP  = {FX3_ADDR_SOCK1, FX3_ADDR_SOCK0},
    localparam int             IW          = $clog2(NREQ)
) (
    input  logic                     clk_pll,
    input  logic                     reset_,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [FX3_DW*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     flaga,
    input  logic                     flagb,
    output logic [1:0]               addr,
    output logic                     slwr_n,
    output logic                     pkend_n,
    output logic [FX3_DW-1:0]        dq_out,
    output logic                     dq_oe,
    output logic                     busy,
    output logic [IW-1:0]            grant_id
`ifdef FX3_WR_ARB_STATS_EN
    ,
    input  logic                     stat_clr,
    output logic [32*NREQ-1:0]       stat_words,
    output logic [31:0]              stat_wait
`endif
);

    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam int SW = (ADDR_SETTLE > 1) ? $clog2(ADDR_SETTLE) : 1;

    fx3_state_e        state_q, state_n;
    logic              flaga_d, flagb_d;
    logic [IW-1:0]     grant, rr_ptr;
    logic [NREQ-1:0]   grant_oh;
    logic [CW-1:0]     word_cnt, cnt_inc;
    logic [SW-1:0]     settle_cnt;
    logic [NREQ-1:0]   arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic [1:0]        map_addr;
    logic [FX3_DW-1:0] sel_data;
    logic              sel_valid, sel_last, ready_en, accept, burst_full;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        map_addr = '0;
        for (int j = 0; j < NREQ; j++)
            if (arb_idx == IW'(j)) map_addr = ADDR_MAP[2*j +: 2];
    end

    always_comb begin
        sel_data = '0;
        for (int j = 0; j < NREQ; j++)
            if (grant_oh[j]) sel_data = sel_data | req_data[FX3_DW*j +: FX3_DW];
    end

    assign sel_valid  = |(req_valid & grant_oh);
    assign sel_last   = |(req_last & grant_oh);
    // Ready never looks at req_valid so sources may use it to launch data.
    assign ready_en   = (state_q == WRITE) && flagb_d && (word_cnt < CW'(BURST_LEN));
    assign req_ready  = grant_oh & {NREQ{ready_en}};
    assign accept     = ready_en && sel_valid;
    assign cnt_inc    = word_cnt + CW'(1);
    assign burst_full = (cnt_inc == CW'(BURST_LEN));

    assign busy     = (state_q != IDLE);
    assign grant_id = grant;

    always_ff @(posedge clk_pll) begin
        if (!reset_) state_q <= IDLE;
        else         state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:       if (|req_valid) state_n = ADDR_SETUP;
            ADDR_SETUP: if (settle_cnt == SW'(ADDR_SETTLE - 1)) state_n = WAIT_FLAGA;
            WAIT_FLAGA: if (flaga_d) state_n = WAIT_FLAGB;
            WAIT_FLAGB: if (flagb_d) state_n = WRITE;
            WRITE:      if (!flagb_d || (accept && (sel_last || burst_full))) state_n = WR_DELAY;
            WR_DELAY:   state_n = RELEASE;
            RELEASE:    state_n = IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_pll) begin
        if (!reset_) begin
            flaga_d    <= 1'b0;
            flagb_d    <= 1'b0;
            slwr_n     <= 1'b1;
            pkend_n    <= 1'b1;
            dq_out     <= '0;
            dq_oe      <= 1'b0;
            addr       <= '0;
            grant      <= '0;
            grant_oh   <= '0;
            rr_ptr     <= '0;
            word_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            flaga_d <= flaga;
            flagb_d <= flagb;
            slwr_n  <= !accept;
            // A last word that exactly fills the burst is not a short packet.
            pkend_n <= !(accept && sel_last && !burst_full);
            if (accept) begin
                dq_out   <= sel_data;
                dq_oe    <= 1'b1;
                word_cnt <= cnt_inc;
            end else if (state_q == WR_DELAY) begin
                dq_oe <= 1'b0;
            end
            case (state_q)
                IDLE: if (|req_valid) begin
                    grant      <= arb_idx;
                    grant_oh   <= arb_gnt;
                    addr       <= map_addr;
                    settle_cnt <= '0;
                end
                ADDR_SETUP: settle_cnt <= settle_cnt + SW'(1);
                RELEASE: begin
                    rr_ptr   <= (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
                    word_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef FX3_WR_ARB_STATS_EN
    always_ff @(posedge clk_pll) begin
        if (!reset_ || stat_clr) begin
            stat_words <= '0;
            stat_wait  <= '0;
        end else begin
            for (int j = 0; j < NREQ; j++)
                if (accept && grant_oh[j]) stat_words[32*j +: 32] <= stat_words[32*j +: 32] + 32'd1;
            if (state_q == WAIT_FLAGA || state_q == WAIT_FLAGB)
                stat_wait <= stat_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fx3_wr_arbiter.sv
// Self-checking bench for fx3_wr_arbiter: queued sources, strobe monitor and a
// burst-level round-robin reference model.
module tb_fx3_wr_arbiter;

    localparam int NREQ = 2;
    localparam int BL   = 4;
    localparam int SETL = 3;

    typedef struct packed {logic [31:0] d; logic l;} word_t;
    typedef struct packed {logic [1:0] a; logic [31:0] d; logic pk; logic g; logic oe;} strobe_t;

    logic              clk_pll = 1'b0;
    logic              reset_;
    logic [NREQ-1:0]   req_valid, req_last, req_ready;
    logic [32*NREQ-1:0] req_data;
    logic              flaga, flagb;
    logic [1:0]        addr;
    logic              slwr_n, pkend_n, dq_oe, busy;
    logic [31:0]       dq_out;
    logic [0:0]        grant_id;
`ifdef FX3_WR_ARB_STATS_EN
    logic              stat_clr;
    logic [32*NREQ-1:0] stat_words;
    logic [31:0]       stat_wait;
`endif

    word_t   srcq [NREQ][$];
    strobe_t obs[$], exp_q[$];
    logic [NREQ-1:0] gate, last_acc;
    bit      gap_en;
    int      checks, errors;

    always #5 clk_pll = ~clk_pll;

    fx3_wr_arbiter #(.NREQ(NREQ), .BURST_LEN(BL), .ADDR_SETTLE(SETL)) dut (
        .clk_pll(clk_pll), .reset_(reset_),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .flaga(flaga), .flagb(flagb), .addr(addr), .slwr_n(slwr_n), .pkend_n(pkend_n),
        .dq_out(dq_out), .dq_oe(dq_oe), .busy(busy), .grant_id(grant_id)
`ifdef FX3_WR_ARB_STATS_EN
        , .stat_clr(stat_clr), .stat_words(stat_words), .stat_wait(stat_wait)
`endif
    );

    function automatic logic [1:0] addr_of(input int r);
        return (r == 0) ? 2'b00 : 2'b01;
    endfunction

    // Reference: whole bursts granted round-robin among requesters holding data;
    // a burst ends on a last word or after BL words.
    function automatic void build_exp(input word_t a0[$], input word_t a1[$], input int ptr);
        word_t m [NREQ][$];
        word_t w;
        int p, r, n;
        m[0] = a0;
        m[1] = a1;
        p = ptr;
        while (m[0].size() + m[1].size() > 0) begin
            r = (m[p].size() > 0) ? p : (p + 1) % NREQ;
            n = 0;
            while (m[r].size() > 0) begin
                w = m[r].pop_front();
                n++;
                exp_q.push_back('{addr_of(r), w.d, w.l && (n < BL), r[0], 1'b1});
                if (w.l || n == BL) break;
            end
            p = (r + 1) % NREQ;
        end
    endfunction

    task automatic load(input int r, input int nw);
        for (int i = 0; i < nw; i++) srcq[r].push_back('{$urandom, (i == nw - 1)});
    endtask

    task automatic drive();
        for (int r = 0; r < NREQ; r++) begin
            if (srcq[r].size() > 0 && gate[r]) begin
                req_valid[r]         = 1'b1;
                req_data[32*r +: 32] = srcq[r][0].d;
                req_last[r]          = srcq[r][0].l;
            end else begin
                req_valid[r]         = 1'b0;
                req_data[32*r +: 32] = '0;
                req_last[r]          = 1'b0;
            end
        end
    endtask

    task automatic step();
        last_acc = req_valid & req_ready & {NREQ{reset_}};
        @(posedge clk_pll);
        #1;
        for (int r = 0; r < NREQ; r++) if (last_acc[r]) void'(srcq[r].pop_front());
        if (gap_en) gate[0] = 1'($urandom_range(0, 1));
        drive();
        if (slwr_n === 1'b0) obs.push_back('{addr, dq_out, ~pkend_n, grant_id, dq_oe});
    endtask

    task automatic run_drain(input int target, output bit ok);
        int n = 0;
        while ((obs.size() < target || busy !== 1'b0) && n < 600) begin
            step();
            n++;
        end
        ok = (n < 600);
    endtask

    task automatic apply_reset();
        reset_ = 1'b0;
        for (int r = 0; r < NREQ; r++) srcq[r].delete();
        drive();
        step();
        step();
        reset_ = 1'b1;
        step();
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        drive();
        step();
        step();
        checks++;
        if ({slwr_n, pkend_n, dq_oe} !== 3'b110) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 110", {slwr_n, pkend_n, dq_oe});
        end
        checks++;
        if ({dq_out, addr} !== 34'd0) begin
            errors++;
            $display("FAIL reset_data_addr: got %h want 0", {dq_out, addr});
        end
        checks++;
        if ({req_ready, busy, grant_id} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000", {req_ready, busy, grant_id});
        end
        reset_ = 1'b1;
        step();
    endtask

    task automatic test_single_packet();
        int n = 0;
        bit ok;
        obs.delete();
        exp_q.delete();
        load(0, 3);
        build_exp(srcq[0], srcq[1], 0);
        drive();
        while (obs.size() == 0 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (n !== 7) begin
            errors++;
            $display("FAIL single_latency: got %0d want 7", n);
        end
        while (obs.size() < 3 && n < 200) begin
            step();
            n++;
        end
        step();
        checks++;
        if ({dq_oe, slwr_n} !== 2'b01) begin
            errors++;
            $display("FAIL single_oe_release: got %b want 01", {dq_oe, slwr_n});
        end
        run_drain(3, ok);
        checks++;
        if (obs.size() != exp_q.size() || !ok) begin
            errors++;
            $display("FAIL single_count: got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_strobe[%0d]: got %h want %h", i, obs[i], exp_q[i]);
            end
        end
        // Pointer moved past requester 0, so requester 1 goes first now.
        obs.delete();
        exp_q.delete();
        load(0, 1);
        load(1, 1);
        build_exp(srcq[0], srcq[1], 1);
        drive();
        run_drain(2, ok);
        checks++;
        if (obs.size() != 2 || !ok) begin
            errors++;
            $display("FAIL ptr_after_single_count: got %0d want 2", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ptr_after_single[%0d]: got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        apply_reset();
        load(0, 8);
        load(1, 8);
        build_exp(srcq[0], srcq[1], 0);
        drive();
        run_drain(16, ok);
        checks++;
        if (obs.size() != exp_q.size() || !ok) begin
            errors++;
            $display("FAIL rr_count: got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rr_strobe[%0d]: got %h want %h", i, obs[i], exp_q[i]);
            end
        end
`ifdef FX3_WR_ARB_STATS_EN
        checks++;
        if (stat_words !== {32'd8, 32'd8} || stat_wait !== 32'd8) begin
            errors++;
            $display("FAIL stats_rr: got %h/%0d want 8,8/8", stat_words, stat_wait);
        end
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        checks++;
        if (stat_words !== '0 || stat_wait !== 32'd0) begin
            errors++;
            $display("FAIL stats_clr: got %h/%0d want 0/0", stat_words, stat_wait);
        end
`endif
    endtask

    task automatic test_flagb_drop();
        word_t a0[$], a1[$], rem[$];
        int nacc = 0, low = 0, n = 0, k = 0;
        bit dropped = 0;
        obs.delete();
        exp_q.delete();
        load(0, 10);
        load(1, 2);
        a0 = srcq[0];
        a1 = srcq[1];
        drive();
        while ((obs.size() < 12 || busy !== 1'b0) && n < 800) begin
            step();
            n++;
            if (last_acc[0]) nacc++;
            if (!dropped && nacc == 2) begin
                flagb = 1'b0;
                dropped = 1;
            end else if (dropped && flagb === 1'b0) begin
                low++;
                if (low == 12) flagb = 1'b1;
            end
        end
        flagb = 1'b1;
        while (k < obs.size() && obs[k].a == 2'b00) k++;
        checks++;
        if (k < 2 || k > 4) begin
            errors++;
            $display("FAIL flagb_first_burst_len: got %0d want 2..4", k);
        end
        for (int i = 0; i < k && i < 10; i++) exp_q.push_back('{2'b00, a0[i].d, 1'b0, 1'b0, 1'b1});
        for (int i = k; i < 10; i++) rem.push_back(a0[i]);
        build_exp(rem, a1, 1);
        checks++;
        if (obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL flagb_count: got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL flagb_strobe[%0d]: got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_flaga_hold();
        int bad = 0, n = 0;
        bit ok;
        obs.delete();
        exp_q.delete();
        flaga = 1'b0;
        load(0, 3);
        build_exp(srcq[0], srcq[1], 0);
        drive();
        repeat (50) begin
            step();
            if (slwr_n !== 1'b1 || dq_oe !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL flaga_hold: got %0d bad cycles busy=%b want 0 busy=1", bad, busy);
        end
        flaga = 1'b1;
        while (obs.size() == 0 && n < 50) begin
            step();
            n++;
        end
        // Registered flags plus the accept register put the strobe a few cycles out.
        checks++;
        if (n < 2 || n > 4) begin
            errors++;
            $display("FAIL flaga_release_latency: got %0d want 2..4", n);
        end
        run_drain(3, ok);
        checks++;
        if (obs.size() != exp_q.size() || !ok) begin
            errors++;
            $display("FAIL flaga_count: got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL flaga_strobe[%0d]: got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        bit ok;
        obs.delete();
        exp_q.delete();
        load(1, 8);
        drive();
        while (obs.size() < 2 && n < 100) begin
            step();
            n++;
        end
        reset_ = 1'b0;
        for (int r = 0; r < NREQ; r++) srcq[r].delete();
        drive();
        step();
        checks++;
        if ({slwr_n, pkend_n, dq_oe, busy, req_ready} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_mid_write: got %b want 110000", {slwr_n, pkend_n, dq_oe, busy, req_ready});
        end
        reset_ = 1'b1;
        step();
        obs.delete();
        load(0, 1);
        load(1, 1);
        build_exp(srcq[0], srcq[1], 0);
        drive();
        run_drain(2, ok);
        checks++;
        if (obs.size() != 2 || !ok) begin
            errors++;
            $display("FAIL post_reset_count: got %0d want 2", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL post_reset_ptr[%0d]: got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_valid_gaps();
        bit ok;
        apply_reset();
        gap_en = 1;
        load(0, 6);
        build_exp(srcq[0], srcq[1], 0);
        drive();
        run_drain(6, ok);
        gap_en = 0;
        gate = '1;
        checks++;
        if (obs.size() != exp_q.size() || !ok) begin
            errors++;
            $display("FAIL gaps_count: got %0d want %0d", obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL gaps_strobe[%0d]: got %h want %h", i, obs[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int round = 0; round < 4; round++) begin
            apply_reset();
            for (int r = 0; r < NREQ; r++)
                repeat ($urandom_range(1, 3)) load(r, $urandom_range(1, 6));
            build_exp(srcq[0], srcq[1], 0);
            drive();
            run_drain(exp_q.size(), ok);
            checks++;
            if (obs.size() != exp_q.size() || !ok) begin
                errors++;
                $display("FAIL random%0d_count: got %0d want %0d", round, obs.size(), exp_q.size());
            end
            for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random%0d_strobe[%0d]: got %h want %h", round, i, obs[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_    = 1'b0;
        flaga     = 1'b1;
        flagb     = 1'b1;
        gate      = '1;
        gap_en    = 0;
        last_acc  = '0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
`ifdef FX3_WR_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        test_reset();
        test_single_packet();
        test_round_robin();
        test_flagb_drop();
        test_flaga_hold();
        test_reset_mid_write();
        test_valid_gaps();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
